sap_control_sequencer: RTL

SAP_CONTROL_SEQUENCER -- requirements
Module: sap_control_sequencer

---
 rtl/sap_pkg.sv | 26 ++
 rtl/sap_control_sequencer_if.sv | 31 +++
 rtl/sap_ring_counter.sv | 56 +++++
 rtl/sap_control_sequencer.sv | 106 ++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared T-state encodings and opcode constants for the SAP control path
package sap_pkg;

    typedef enum logic [2:0] {
        T1     = 3'd0,
        T2     = 3'd1,
        T3     = 3'd2,
        T4     = 3'd3,
        T5     = 3'd4,
        T6     = 3'd5,
        T_HALT = 3'd7
    } t_state_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Anything outside the defined opcode set executes as a NOP.
    function automatic logic is_nop(input logic [3:0] op);
        return !(op == OP_LDA || op == OP_ADD || op == OP_SUB ||
                 op == OP_OUT || op == OP_HLT);
    endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// rtl/sap_control_sequencer_if.sv - run/opcode inputs and control-line bundle of the sequencer
interface sap_control_sequencer_if;
    logic       run;
    logic [3:0] instruction;
    logic [2:0] t_state;
    logic       pc_inc;
    logic       pc_enable;
    logic       mar_latch;
    logic       ram_enable;
    logic       ir_latch;
    logic       ir_enable;
    logic       a_latch;
    logic       a_enable;
    logic       b_latch;
    logic       alu_enable;
    logic       alu_sub;
    logic       out_latch;
    logic       halt;

    modport master (
        input  run, instruction,
        output t_state, pc_inc, pc_enable, mar_latch, ram_enable, ir_latch, ir_enable,
               a_latch, a_enable, b_latch, alu_enable, alu_sub, out_latch, halt
    );

    modport slave (
        output run, instruction,
        input  t_state, pc_inc, pc_enable, mar_latch, ram_enable, ir_latch, ir_enable,
               a_latch, a_enable, b_latch, alu_enable, alu_sub, out_latch, halt
    );
endinterface

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - T-state register with run hold, short-cycle return and HALT trap
module sap_ring_counter
    import sap_pkg::*;
#(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] instruction,
    output t_state_e   t_state
);

    t_state_e state_q;
    t_state_e state_d;

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = T1;
        end else if (state_q == T_HALT) begin
            state_d = T_HALT;
        end else if (run) begin
            case (state_q)
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    if (instruction == OP_HLT) begin
                        state_d = T_HALT;
                    end else if (SHORT_CYCLE && (instruction == OP_OUT || is_nop(instruction))) begin
                        state_d = T1;
                    end else begin
                        state_d = T5;
                    end
                end
                T5: begin
                    if (SHORT_CYCLE && instruction == OP_LDA) begin
                        state_d = T1;
                    end else begin
                        state_d = T6;
                    end
                end
                // T6 and the unused encoding both wrap to the next fetch.
                default: state_d = T1;
            endcase
        end
    end

    assign t_state = state_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP control sequencer: ring counter plus combinational control decode
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] INSTRUCTION,
    output logic [2:0] T_STATE,
    output logic       pc_inc,
    output logic       pc_enable,
    output logic       mar_latch,
    output logic       ram_enable,
    output logic       ir_latch,
    output logic       ir_enable,
    output logic       a_latch,
    output logic       a_enable,
    output logic       b_latch,
    output logic       alu_enable,
    output logic       alu_sub,
    output logic       out_latch,
    output logic       halt
);

    t_state_e state;

    sap_ring_counter #(
        .SHORT_CYCLE(SHORT_CYCLE)
    ) u_ring (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .instruction(INSTRUCTION),
        .t_state    (state)
    );

    // Reset masks everything combinationally so the bus is quiet during the reset cycle itself.
    always_comb begin
        T_STATE    = 3'd0;
        pc_inc     = 1'b0;
        pc_enable  = 1'b0;
        mar_latch  = 1'b0;
        ram_enable = 1'b0;
        ir_latch   = 1'b0;
        ir_enable  = 1'b0;
        a_latch    = 1'b0;
        a_enable   = 1'b0;
        b_latch    = 1'b0;
        alu_enable = 1'b0;
        alu_sub    = 1'b0;
        out_latch  = 1'b0;
        halt       = 1'b0;
        if (!reset) begin
            T_STATE = state;
            case (state)
                T1: begin
                    pc_enable = 1'b1;
                    mar_latch = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_enable = 1'b1;
                    ir_latch   = 1'b1;
                end
                T4: begin
                    case (INSTRUCTION)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_enable = 1'b1;
                            mar_latch = 1'b1;
                        end
                        OP_OUT: begin
                            a_enable  = 1'b1;
                            out_latch = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (INSTRUCTION)
                        OP_LDA: begin
                            ram_enable = 1'b1;
                            a_latch    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_enable = 1'b1;
                            b_latch    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (INSTRUCTION == OP_ADD || INSTRUCTION == OP_SUB) begin
                        alu_enable = 1'b1;
                        a_latch    = 1'b1;
                        alu_sub    = (INSTRUCTION == OP_SUB);
                    end
                end
                T_HALT: halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
